// File: rtl/demux_rr_arbiter_if.sv
// Request/grant bundle between the requester logic and the demux-sharing arbiter.
// The master side drives requests; the slave side (the arbiter) returns the grant.
interface demux_rr_arbiter_if;
    logic [7:0] REQ;
    logic       GRANT_EN;
    logic [2:0] GRANT_IDX;
    logic [7:0] GRANT;
    logic       TIMEOUT;

    modport master (
        output REQ,
        input  GRANT_EN,
        input  GRANT_IDX,
        input  GRANT,
        input  TIMEOUT
    );

    modport slave (
        input  REQ,
        output GRANT_EN,
        output GRANT_IDX,
        output GRANT,
        output TIMEOUT
    );
endinterface

// File: rtl/demux_rr_arbiter.sv
// Round-robin arbiter sharing a 3-to-8 demux among 8 requesters, with a bounded
// grant length and a one-cycle idle gap between consecutive grants.
module demux_rr_arbiter #(
    parameter int unsigned MAX_GRANT = 8
) (
    input logic                CLK,
    input logic                RST_N,
    demux_rr_arbiter_if.slave  bus
);

    localparam logic [7:0] CntLast = 8'(MAX_GRANT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StRelease
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] grant_q, grant_d;
    logic       en_q, en_d;
    logic       timeout_q, timeout_d;

    logic [2:0] search_base;
    logic [2:0] cand;
    logic [2:0] winner;
    logic       found;

    // In RELEASE the search already starts past the index just served.
    always_comb begin
        search_base = (state_q == StRelease) ? idx_q + 3'd1 : ptr_q;
        cand        = 3'd0;
        winner      = 3'd0;
        found       = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cand = search_base + 3'(i);
            if (!found && bus.REQ[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        en_d      = en_q;
        timeout_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                en_d    = 1'b0;
                grant_d = 8'h00;
                if (found) begin
                    state_d = StGrant;
                    idx_d   = winner;
                    en_d    = 1'b1;
                    grant_d = 8'h01 << winner;
                    cnt_d   = 8'd0;
                end
            end
            StGrant: begin
                cnt_d = cnt_q + 8'd1;
                // A dropped request wins over the limit, so TIMEOUT stays low then.
                if (!bus.REQ[idx_q]) begin
                    state_d = StRelease;
                    en_d    = 1'b0;
                    grant_d = 8'h00;
                end else if (cnt_q == CntLast) begin
                    state_d   = StRelease;
                    en_d      = 1'b0;
                    grant_d   = 8'h00;
                    timeout_d = 1'b1;
                end
            end
            StRelease: begin
                ptr_d   = idx_q + 3'd1;
                en_d    = 1'b0;
                grant_d = 8'h00;
                if (found) begin
                    state_d = StGrant;
                    idx_d   = winner;
                    en_d    = 1'b1;
                    grant_d = 8'h01 << winner;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                en_d    = 1'b0;
                grant_d = 8'h00;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StIdle;
            idx_q     <= 3'd0;
            ptr_q     <= 3'd0;
            cnt_q     <= 8'd0;
            grant_q   <= 8'h00;
            en_q      <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            en_q      <= en_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.GRANT_EN  = en_q;
    assign bus.GRANT_IDX = idx_q;
    assign bus.GRANT     = grant_q;
    assign bus.TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_demux_rr_arbiter.sv
// Directed bench for demux_rr_arbiter: reset, single requester, fairness, wrap-around,
// drop-vs-limit precedence and asynchronous reset mid-grant.
module tb_demux_rr_arbiter;

    logic CLK;
    logic RST_N;
    int   checks;
    int   failures;

    demux_rr_arbiter_if bus ();

    demux_rr_arbiter #(
        .MAX_GRANT (8)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected GRANT is derived from the expected enable and index.
    task automatic chk_out(input string tag, input logic en, input logic [2:0] idx,
                           input logic to);
        logic [7:0] g;
        g = en ? (8'h01 << idx) : 8'h00;
        chk({tag, ".en"}, 32'(bus.GRANT_EN), 32'(en));
        chk({tag, ".idx"}, 32'(bus.GRANT_IDX), 32'(idx));
        chk({tag, ".grant"}, 32'(bus.GRANT), 32'(g));
        chk({tag, ".timeout"}, 32'(bus.TIMEOUT), 32'(to));
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Reset with every requester asserted
        RST_N   = 1'b0;
        bus.REQ = 8'hFF;
        #2;
        chk_out("rst_async", 1'b0, 3'd0, 1'b0);
        step();
        chk_out("rst_held", 1'b0, 3'd0, 1'b0);
        #3;
        RST_N = 1'b1;
        step();
        chk_out("rst_first_grant", 1'b1, 3'd0, 1'b0);

        // Fairness: 0..7 then 0 again, 8 cycles each, 1-cycle gap with TIMEOUT
        for (int g = 0; g <= 8; g++) begin
            for (int c = 1; c < 8; c++) begin
                step();
                chk_out($sformatf("fair_g%0d_c%0d", g, c), 1'b1, 3'(g % 8), 1'b0);
            end
            step();
            chk_out($sformatf("fair_gap%0d", g), 1'b0, 3'(g % 8), 1'b1);
            if (g < 8) begin
                step();
                chk_out($sformatf("fair_start%0d", g + 1), 1'b1, 3'((g + 1) % 8), 1'b0);
            end
        end
        bus.REQ = 8'h00;
        step();
        chk_out("fair_to_idle", 1'b0, 3'd0, 1'b0);

        // Single requester 5 for 3 cycles
        bus.REQ = 8'h20;
        step();
        chk_out("single_c0", 1'b1, 3'd5, 1'b0);
        step();
        chk_out("single_c1", 1'b1, 3'd5, 1'b0);
        step();
        chk_out("single_c2", 1'b1, 3'd5, 1'b0);
        bus.REQ = 8'h00;
        step();
        chk_out("single_release", 1'b0, 3'd5, 1'b0);
        step();
        chk_out("single_idle", 1'b0, 3'd5, 1'b0);

        // Wrap-around: grant 6 ends, then REQ=41 -> 0 first, 6 next
        bus.REQ = 8'h40;
        step();
        chk_out("wrap_g6_c0", 1'b1, 3'd6, 1'b0);
        step();
        chk_out("wrap_g6_c1", 1'b1, 3'd6, 1'b0);
        bus.REQ = 8'h00;
        step();
        chk_out("wrap_g6_release", 1'b0, 3'd6, 1'b0);
        bus.REQ = 8'h41;
        step();
        chk_out("wrap_g0_c0", 1'b1, 3'd0, 1'b0);
        for (int c = 1; c < 8; c++) begin
            step();
            chk_out($sformatf("wrap_g0_c%0d", c), 1'b1, 3'd0, 1'b0);
        end
        step();
        chk_out("wrap_gap", 1'b0, 3'd0, 1'b1);
        step();
        chk_out("wrap_g6_again", 1'b1, 3'd6, 1'b0);
        bus.REQ = 8'h00;
        step();
        chk_out("wrap_release2", 1'b0, 3'd6, 1'b0);
        step();
        chk_out("wrap_idle", 1'b0, 3'd6, 1'b0);

        // Requester 2 drops exactly on the last allowed cycle
        bus.REQ = 8'h04;
        step();
        chk_out("sim_c0", 1'b1, 3'd2, 1'b0);
        for (int c = 1; c < 8; c++) begin
            step();
            chk_out($sformatf("sim_c%0d", c), 1'b1, 3'd2, 1'b0);
        end
        bus.REQ = 8'h00;
        step();
        chk_out("sim_release_no_timeout", 1'b0, 3'd2, 1'b0);
        step();
        chk_out("sim_idle", 1'b0, 3'd2, 1'b0);

        // Asynchronous reset while granting index 3
        bus.REQ = 8'h08;
        step();
        chk_out("arst_g3_c0", 1'b1, 3'd3, 1'b0);
        step();
        chk_out("arst_g3_c1", 1'b1, 3'd3, 1'b0);
        #2;
        RST_N = 1'b0;
        #1;
        chk_out("arst_cleared", 1'b0, 3'd0, 1'b0);
        #2;
        RST_N = 1'b1;
        step();
        chk_out("arst_regrant", 1'b1, 3'd3, 1'b0);

        bus.REQ = 8'h00;
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
